// File: rtl/imem_loadable_pkg.sv
// Shared processor definitions used by the instruction memory and the decoder:
// default instruction width, the NOP encoding and the loader FSM states.
package imem_loadable_pkg;

  localparam int          DEFAULT_DATA_W   = 32;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h00360000;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Collects loader bytes little-endian into instruction words and strobes
// word_done on the cycle the final byte of a word is accepted.
module imem_byte_packer
  import imem_loadable_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data_byte,
  output logic              word_done,
  output logic [DATA_W-1:0] word,
  output logic              pending
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [CW-1:0] cnt;

  assign word_done = accept && (cnt == LAST);
  // pending reflects the count after this cycle's byte, so a byte arriving
  // together with load_end is taken into account before the partial check
  assign pending   = accept ? (cnt != LAST) : (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= word_done ? '0 : cnt + CW'(1);
    end
  end

  generate
    if (DATA_W > 8) begin : g_shift
      // earlier bytes sit right-aligned; the newest byte becomes the top byte
      logic [DATA_W-9:0] shift;

      assign word = {data_byte, shift};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shift <= '0;
        end else if (accept) begin
          shift <= word[DATA_W-1:8];
        end
      end
    end else begin : g_single
      assign word = data_byte;
    end
  endgenerate

endmodule

// File: rtl/imem_loadable.sv
// Writable instruction memory: registered one-cycle fetch port plus a
// byte-serial loader that stalls fetch while a new program is written.
module imem_loadable
  import imem_loadable_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = DEFAULT_DATA_W,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_words,
  output logic              load_err
);

  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  imem_state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic              full;
  logic              byte_accept;
  logic              packer_clear;
  logic              word_done;
  logic [DATA_W-1:0] word;
  logic              pending;
  logic              fetch_accept;
  logic              in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_d;
    end
  end

  // a load_start seen in LOAD keeps us in LOAD; the datapath restarts
  always_comb begin
    state_d = state;
    case (state)
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && load_end) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    case (state)
      RUN:     fetch_ready = 1'b1;
      LOAD:    load_ready  = 1'b1;
      default: fetch_ready = 1'b1;
    endcase
  end

  assign full         = (wr_ptr == DEPTH_W);
  assign byte_accept  = load_valid && load_ready && !load_start;
  assign packer_clear = load_start || (load_end && load_ready);
  assign load_words   = wr_ptr;

  imem_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (packer_clear),
    .accept    (byte_accept),
    .data_byte (load_byte),
    .word_done (word_done),
    .word      (word),
    .pending   (pending)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      load_err <= 1'b0;
    end else if (load_start) begin
      wr_ptr   <= '0;
      load_err <= 1'b0;
    end else if (load_ready) begin
      if (word_done && !full) begin
        wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
      end
      if ((byte_accept && full) || (load_end && pending)) begin
        load_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && word_done && !full) begin
      mem[wr_ptr[MAW-1:0]] <= word;
    end
  end

  assign fetch_accept = fetch_req && fetch_ready;
  assign in_range     = ({1'b0, fetch_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_accept) begin
        fetch_data <= in_range ? mem[fetch_addr[MAW-1:0]] : NOP_WORD;
      end
    end
  end

endmodule
